// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: two-requester round-robin front end for a shared multi-cycle
// FP32 multiplier core. One operation in flight; a watchdog forces a quiet-NaN
// completion if the core never reports done.
// Optional feature macro: FP_MUL_STICKY_FLAGS_EN (per-requester sticky flags).
module fp_mul_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [31:0] mul_result,
  input  logic        mul_invalid,
  input  logic        mul_overflow,
  input  logic        mul_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  sticky_flags0,
  output logic [3:0]  sticky_flags1,
  input  logic [1:0]  sticky_clr
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic             rsp_id_q, rsp_id_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             grant;

  // Sequencer: round-robin grant, core issue, completion/timeout wait, response hold
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    req_ready    = '0;
    mul_start    = 1'b0;
    rsp_valid    = 1'b0;
    // Contention favours the requester not served last; otherwise the lone requester wins
    grant        = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready    = grant ? 2'b10 : 2'b01;
          mul_a_d      = grant ? req_a1 : req_a0;
          mul_b_d      = grant ? req_b1 : req_b0;
          rsp_id_d     = grant;
          last_grant_d = grant;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (mul_done) begin
          rsp_result_d = mul_result;
          rsp_flags_d  = {1'b0, mul_zero, mul_overflow, mul_invalid};
          state_d      = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_result_d = QNAN;
          rsp_flags_d  = 4'b1001;
          state_d      = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

`ifdef FP_MUL_STICKY_FLAGS_EN
  logic [3:0] sticky0_q, sticky0_d;
  logic [3:0] sticky1_q, sticky1_d;
  logic       rsp_fire;

  // Accumulate flags at each accepted response; a same-cycle clear yields just the new flags
  always_comb begin
    rsp_fire  = rsp_valid & rsp_ready;
    sticky0_d = sticky0_q;
    sticky1_d = sticky1_q;
    if (rsp_fire && !rsp_id_q)
      sticky0_d = sticky_clr[0] ? rsp_flags_q : (sticky0_q | rsp_flags_q);
    else if (sticky_clr[0])
      sticky0_d = '0;
    if (rsp_fire && rsp_id_q)
      sticky1_d = sticky_clr[1] ? rsp_flags_q : (sticky1_q | rsp_flags_q);
    else if (sticky_clr[1])
      sticky1_d = '0;
  end

  // Sticky flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky0_q <= '0;
      sticky1_q <= '0;
    end else begin
      sticky0_q <= sticky0_d;
      sticky1_q <= sticky1_d;
    end
  end

  assign sticky_flags0 = sticky0_q;
  assign sticky_flags1 = sticky1_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = ^sticky_clr;
  assign sticky_flags0     = '0;
  assign sticky_flags1     = '0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed table, hand-written corner sequences and random
// traffic against a transaction-level model of grant order, latency, results
// and sticky flags. Core is emulated with a programmable done latency.
module tb_fp_mul_arbiter;
  localparam int unsigned TO = 8;
`ifdef FP_MUL_STICKY_FLAGS_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic        mul_start;
  logic [31:0] mul_a, mul_b;
  logic        mul_done = 1'b0;
  logic [31:0] mul_result = '0;
  logic        mul_invalid = 1'b0, mul_overflow = 1'b0, mul_zero = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [3:0]  sticky_flags0, sticky_flags1;
  logic [1:0]  sticky_clr = '0;

  fp_mul_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
    .mul_result(mul_result), .mul_invalid(mul_invalid), .mul_overflow(mul_overflow),
    .mul_zero(mul_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .sticky_flags0(sticky_flags0),
    .sticky_flags1(sticky_flags1), .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pat;
    logic [31:0] a0, b0, a1, b1;
    int          lat;       // core done latency after first WAIT cycle; -1 = never
    logic [31:0] cres;
    logic [2:0]  cflg;      // {zero, overflow, invalid}
    int          stall;
    logic [1:0]  clr;       // sticky_clr driven during the accept cycle
    logic        exp_id;
    logic [31:0] exp_res;
    logic [3:0]  exp_flg;
    int          exp_lat;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         core_cnt = 0;
  int         core_lat = -1;
  int         both_cnt = 0;
  logic       m_last = 1'b1;
  logic [3:0] m_stk [2];
  logic       hs_pend = 1'b0;
  logic       hs_id = 1'b0;
  logic [3:0] hs_flags = '0;
  vec_t       tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_stk(input int n);
    return STICKY_EN ? m_stk[n] : 4'b0;
  endfunction

  // Response predicted from the core behaviour and the timeout budget alone
  task automatic model_rsp(input int lat, input logic [31:0] cres, input logic [2:0] cflg,
                           output logic [31:0] r, output logic [3:0] f, output int l);
    if (lat >= 0 && lat <= int'(TO) - 1) begin
      r = cres; f = {1'b0, cflg}; l = lat + 3;
    end else begin
      r = 32'h7FC0_0000; f = 4'b1001; l = int'(TO) + 2;
    end
  endtask

  // One clock: update sticky model with this cycle's accept/clear, then emulate the core
  task automatic tick();
    if (rst) begin
      m_stk[0] = '0; m_stk[1] = '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (hs_pend && int'(hs_id) == n)
          m_stk[n] = sticky_clr[n] ? hs_flags : (m_stk[n] | hs_flags);
        else if (sticky_clr[n])
          m_stk[n] = '0;
      end
    end
    hs_pend = 1'b0;
    @(posedge clk);
    #1;
    mul_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) mul_done = 1'b1;
    end
    if (mul_start && core_lat >= 0) core_cnt = core_lat + 1;
    if (req_ready == 2'b11) both_cnt++;
  endtask

  task automatic look();
    #1;
    if (req_ready == 2'b11) both_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; sticky_clr = '0;
    core_cnt = 0; core_lat = -1; mul_done = 1'b0;
    tick(); tick();
    rst = 1'b0; m_last = 1'b1;
  endtask

  // Full transaction from grant to accept; DUT must be idle on entry
  task automatic do_op(input vec_t v, input string tag);
    int n;
    int bad;
    req_a0 = v.a0; req_b0 = v.b0; req_a1 = v.a1; req_b1 = v.b1;
    req_valid = v.pat; core_lat = v.lat; mul_result = v.cres;
    {mul_zero, mul_overflow, mul_invalid} = v.cflg;
    look();
    chk({tag, ":grant"}, req_ready, v.exp_id ? 2'b10 : 2'b01);
    m_last = v.exp_id;
    tick();
    req_valid[v.exp_id] = 1'b0;
    chk({tag, ":mul_start"}, mul_start, 1'b1);
    chk({tag, ":mul_a"}, mul_a, v.exp_id ? v.a1 : v.a0);
    chk({tag, ":mul_b"}, mul_b, v.exp_id ? v.b1 : v.b0);
    n = 1;
    while (!rsp_valid && n < 64) begin
      tick();
      n++;
    end
    chk({tag, ":latency"}, n, v.exp_lat);
    chk({tag, ":rsp_id"}, rsp_id, v.exp_id);
    chk({tag, ":rsp_result"}, rsp_result, v.exp_res);
    chk({tag, ":rsp_flags"}, rsp_flags, v.exp_flg);
    bad = 0;
    for (int i = 0; i < v.stall; i++) begin
      tick();
      if (!rsp_valid || rsp_id !== v.exp_id || rsp_result !== v.exp_res || rsp_flags !== v.exp_flg)
        bad++;
    end
    chk({tag, ":stall_stable"}, bad, 0);
    rsp_ready = 1'b1; sticky_clr = v.clr;
    hs_pend = 1'b1; hs_id = v.exp_id; hs_flags = v.exp_flg;
    tick();
    rsp_ready = 1'b0; sticky_clr = '0;
    chk({tag, ":rsp_dropped"}, rsp_valid, 1'b0);
    chk({tag, ":sticky0"}, sticky_flags0, exp_stk(0));
    chk({tag, ":sticky1"}, sticky_flags1, exp_stk(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   bad;
    m_stk[0] = '0; m_stk[1] = '0;

    tbl[0] = '{2'b10, 32'h1, 32'h2, 32'h0000_0000, 32'h7F80_0000, 2, 32'h7FC0_0000, 3'b001, 5, 2'b00,
               1'b1, 32'h7FC0_0000, 4'b0001, 5};
    tbl[1] = '{2'b01, 32'h4000_0000, 32'h4040_0000, 32'h3, 32'h4, 4, 32'h40C0_0000, 3'b000, 0, 2'b00,
               1'b0, 32'h40C0_0000, 4'b0000, 7};
    tbl[2] = '{2'b10, 32'h5, 32'h6, 32'h3F80_0000, 32'h3F80_0000, -1, 32'h1234_5678, 3'b111, 2, 2'b00,
               1'b1, 32'h7FC0_0000, 4'b1001, 10};
    tbl[3] = '{2'b01, 32'h4120_0000, 32'h3F80_0000, 32'h7, 32'h8, 7, 32'h4120_0000, 3'b000, 0, 2'b00,
               1'b0, 32'h4120_0000, 4'b0000, 10};
    tbl[4] = '{2'b01, 32'h7F00_0000, 32'h4000_0000, 32'h9, 32'hA, 0, 32'h7F80_0000, 3'b010, 1, 2'b00,
               1'b0, 32'h7F80_0000, 4'b0010, 3};
    tbl[5] = '{2'b10, 32'hB, 32'hC, 32'h0000_0001, 32'h0000_0001, 1, 32'h0000_0000, 3'b100, 0, 2'b10,
               1'b1, 32'h0000_0000, 4'b0100, 4};

    do_reset();
    chk("reset:req_ready", req_ready, 2'b00);
    chk("reset:mul_start", mul_start, 1'b0);
    chk("reset:rsp_valid", rsp_valid, 1'b0);
    chk("reset:rsp_result", rsp_result, 32'h0);
    chk("reset:sticky0", sticky_flags0, 4'h0);

    for (int i = 0; i < 6; i++) do_op(tbl[i], $sformatf("tbl%0d", i));

    // Clear both sticky registers with a one-cycle pulse
    sticky_clr = 2'b11;
    tick();
    sticky_clr = '0;
    chk("clr:sticky0", sticky_flags0, 4'h0);
    chk("clr:sticky1", sticky_flags1, 4'h0);

    // Random traffic against the transaction model
    for (int k = 0; k < 40; k++) begin
      v.pat   = 2'($urandom_range(1, 3));
      v.a0    = $urandom; v.b0 = $urandom; v.a1 = $urandom; v.b1 = $urandom;
      v.lat   = int'($urandom_range(0, 11));
      if (v.lat == 11) v.lat = -1;
      v.cres  = $urandom;
      v.cflg  = 3'($urandom);
      v.stall = int'($urandom_range(0, 3));
      v.clr   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      v.exp_id = (v.pat == 2'b11) ? ~m_last : v.pat[1];
      model_rsp(v.lat, v.cres, v.cflg, v.exp_res, v.exp_flg, v.exp_lat);
      do_op(v, $sformatf("rnd%0d", k));
      req_valid = '0;
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 4) == 0) sticky_clr = 2'($urandom);
        tick();
        sticky_clr = '0;
      end
    end

    // Reset while waiting on the core, then a late done pulse that must be ignored
    req_a0 = 32'hDEAD_BEEF; req_b0 = 32'h1234_5678; req_valid = 2'b01; core_lat = -1;
    look();
    chk("rstwait:grant", req_ready, 2'b01);
    tick();
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; m_last = 1'b1; core_cnt = 1;
    chk("rstwait:req_ready", req_ready, 2'b00);
    chk("rstwait:mul_start", mul_start, 1'b0);
    chk("rstwait:mul_a", mul_a, 32'h0);
    chk("rstwait:mul_b", mul_b, 32'h0);
    chk("rstwait:rsp_valid", rsp_valid, 1'b0);
    chk("rstwait:rsp_id", rsp_id, 1'b0);
    chk("rstwait:rsp_result", rsp_result, 32'h0);
    chk("rstwait:rsp_flags", rsp_flags, 4'h0);
    chk("rstwait:sticky0", sticky_flags0, exp_stk(0));
    chk("rstwait:sticky1", sticky_flags1, exp_stk(1));
    bad = 0;
    repeat (6) begin
      tick();
      if (rsp_valid || mul_start) bad++;
    end
    chk("rstwait:late_done_ignored", bad, 0);
    v = '{2'b10, 32'h0, 32'h0, 32'h3F80_0000, 32'h4000_0000, 0, 32'h4000_0000, 3'b000, 0, 2'b00,
          1'b1, 32'h4000_0000, 4'b0000, 3};
    do_op(v, "rstwait:after");

    // Both requesters held valid: grants alternate starting opposite the reset last-grant
    do_reset();
    both_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      v = '{2'b11, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, k,
            32'h4100_0000 + 32'(k), 3'b000, 0, 2'b00,
            (k % 2 == 1), 32'h4100_0000 + 32'(k), 4'b0000, k + 3};
      do_op(v, $sformatf("alt%0d", k));
    end
    req_valid = '0;
    chk("never_both_ready", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
